pixel_row_packer: RTL
=====================

# pixel_row_packer

Upstream stage of `median_filter`. It accepts a raster pixel stream one `WIDTH`-bit pixel per clock under a valid/ready handshake and packs each group of `COLS` pixels into one full-width row word. It presents each row to the filter on `row_out` with its own valid/ready handshake. Packing is double-buffered: a fill buffer and an output register, so pixel intake continues while the previous row waits to be taken.

## Interface
- `COLS`, 512, pixels per row
- `ROWS`, 512, rows per frame
- `WIDTH`, 8, bits per pixel
- `CLK`  in  1  clock, all logic on rising edge
- `RST`  in  1  synchronous reset, active-high
- `pix_in`  in  WIDTH  pixel value
- `pix_valid`  in  1  `pix_in` valid
- `sof`  in  1  start of frame; qualified by the pixel handshake, marks pixel (row 0, col 0)
- `pix_ready`  out  1  packer can accept a pixel this cycle (registered)
- `row_out`  out  COLS*WIDTH  packed row; pixel k at bits [COLS*WIDTH-1-k*WIDTH -: WIDTH] (pixel 0 in MSBs)
- `row_valid`  out  1  `row_out` holds a complete row
- `row_ready`  in  1  downstream takes the row
- `row_idx`  out  $clog2(ROWS)  row number of the row on `row_out`
- `row_last`  out  1  `row_idx == ROWS-1`, valid with `row_valid`
- `sync_err`  out  1  one-cycle pulse: partial row discarded by a mid-row `sof`

## Operation
- Pixel accept: `pix_valid && pix_ready`. The accepted pixel is written to fill-buffer slot `col`, then `col` increments.
- Fill FSM has two states:
  - FILLING: `pix_ready` = 1.
  - HELD: fill buffer complete, output register occupied, `pix_ready` = 0.
- `slot_free` = `!row_valid || row_ready`.
- Accept of the pixel at `col == COLS-1`:
  - If `slot_free`, load `row_out` with the completed row, including this pixel. Set `row_valid`, `col` = 0, stay in FILLING.
  - Otherwise go to HELD, `col` = 0.
- In HELD: when `slot_free`, load `row_out` from the fill buffer, set `row_valid`, return to FILLING.
- Output handshake:
  - `row_valid && row_ready` with no new load: clear `row_valid`.
  - Load and consume in the same cycle: new row replaces old, `row_valid` stays 1.
  - `row_out`, `row_idx` and `row_last` stay stable while `row_valid && !row_ready`.
- Row counter:
  - Each load into `row_out` copies the fill row number into `row_idx`.
  - The fill row number increments after the load and wraps from ROWS-1 to 0.
- `sof` on an accepted pixel:
  - Pixel goes to col 0, fill row number = 0.
  - If `col != 0` at that moment, the partial row is discarded and `sync_err` pulses next cycle.
  - `sof` at `col == 0` with fill row number != 0 (short frame) resyncs silently, no `sync_err`.
  - `sof` is ignored without a pixel handshake.
- Rows already in `row_out` or held are unaffected by `sof`; they keep their original `row_idx`.
- No arithmetic on pixel data; values pass bit-exact.

## Timing
- Reset values: `pix_ready` = 1, `row_valid` = 0, `row_out` = 0, `row_idx` = 0, `row_last` = 0, `sync_err` = 0. `col` = 0, fill row = 0, FSM = FILLING.
- `RST` mid-row or in HELD drops all buffered data, with no `sync_err`.
- Latency: `row_valid` rises on the clock edge that accepts the last pixel of the row when `slot_free`. Otherwise it rises on the edge after `slot_free` in HELD.
- Throughput: 1 pixel/cycle sustained when downstream takes each row within COLS cycles.
- HELD to FILLING: `pix_ready` returns to 1 on the same edge as the load, so it is visible in the next cycle.
- `pix_ready` must not depend combinationally on `row_ready`.

## Test plan
- Reset, then stream 2 rows with pixel k = k mod 256 and `row_ready` = 1:
  - `row_valid` pulses 1 cycle after pixel 511 and pixel 1023 accepts.
  - `row_out[4095:4088]` = 0x00 and `row_out[7:0]` = 0xFF.
  - `row_idx` = 0 for the first row and 1 for the second.
  - `pix_ready` stays 1 throughout.
- Hold `row_ready` = 0 and stream 3 rows:
  - Row 0 is held on `row_out`.
  - After row 1 completes, `pix_ready` = 0 (HELD).
  - Raise `row_ready` for 1 cycle: row 1 loads, `pix_ready` = 1 the next cycle, row 2 is accepted, no pixel is lost.
- Full frame of 512 rows with random pixels and random `pix_valid`/`row_ready`:
  - Every row matches the model bit-exact.
  - `row_last` = 1 only for `row_idx` = 511.
  - Next frame restarts at `row_idx` 0.
- Assert `sof` at col 200 of row 5:
  - `sync_err` pulses 1 cycle.
  - Next emitted row has `row_idx` 0 and starts with the `sof` pixel.
  - Row 4, already on `row_out`, is delivered with `row_idx` 4.
- Assert `RST` for 1 cycle while in HELD with `row_valid` = 1:
  - Next cycle: `row_valid` = 0, `pix_ready` = 1, `row_out` = 0.
  - A subsequent row is emitted with `row_idx` 0.
- Equal rows, all pixels 0xFF:
  - `row_out` = all ones.
  - Load and consume in the same cycle keeps `row_valid` high with no bubble.

Source files
------------

// File: rtl/pixel_row_packer.sv
// pixel_row_packer
//
// Packs a raster pixel stream (one WIDTH-bit pixel per clock, valid/ready)
// into COLS-pixel row words, pixel 0 in the MSBs. Rows are double-buffered:
// a fill buffer collects the next row while the output register holds the
// previous one until the consumer takes it.
//
// Ports:
//   CLK        clock, all logic on rising edge
//   RST        synchronous reset, active-high
//   pix_in     pixel value
//   pix_valid  pix_in valid
//   sof        start of frame, qualified by the pixel handshake
//   pix_ready  packer can accept a pixel this cycle (registered)
//   row_out    packed row, pixel k at [COLS*WIDTH-1-k*WIDTH -: WIDTH]
//   row_valid  row_out holds a complete row
//   row_ready  downstream takes the row
//   row_idx    row number of the row on row_out
//   row_last   row_idx == ROWS-1, valid with row_valid
//   sync_err   one-cycle pulse: partial row discarded by a mid-row sof
module pixel_row_packer #(
    parameter int COLS  = 512,
    parameter int ROWS  = 512,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic                     pix_ready,
    output logic [COLS*WIDTH-1:0]    row_out,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     row_last,
    output logic                     sync_err
);

    localparam int CW  = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);
    localparam int RW  = COLS * WIDTH;

    localparam logic [0:0] ST_FILLING = 1'b0;
    localparam logic [0:0] ST_HELD    = 1'b1;

    logic [0:0]     state;
    logic [CW-1:0]  col;
    logic [RIW-1:0] fill_row;
    logic [RW-1:0]  fill_buf;
    logic [RW-1:0]  fill_next;

    logic           accept;
    logic           slot_free;
    logic [CW-1:0]  wr_col;
    logic [RIW-1:0] wr_row;
    logic           row_done;
    logic           load;
    logic [RIW-1:0] load_row;
    logic [RIW-1:0] row_inc;

    // pix_ready is only ever high in FILLING, so accept implies FILLING.
    assign accept    = pix_valid && pix_ready;
    assign slot_free = !row_valid || row_ready;

    // An accepted sof pixel restarts the row at col 0 of frame row 0.
    assign wr_col   = sof ? '0 : col;
    assign wr_row   = sof ? '0 : fill_row;
    assign row_done = accept && (wr_col == CW'(COLS - 1));

    assign load = ((state == ST_FILLING) && row_done && slot_free) ||
                  ((state == ST_HELD) && slot_free);

    // In HELD no pixel is accepted, so fill_row is still the held row's number.
    assign load_row = (state == ST_HELD) ? fill_row : wr_row;
    assign row_inc  = (load_row == RIW'(ROWS - 1)) ? '0 : load_row + RIW'(1);

    // Fill buffer with the current pixel merged in; in HELD this equals
    // fill_buf, so row_out can always load from here.
    always_comb begin
        fill_next = fill_buf;
        if (accept) begin
            fill_next[RW-1-int'(wr_col)*WIDTH -: WIDTH] = pix_in;
        end
    end

    // Pixel storage needs no reset: every slot is rewritten before a row loads.
    always_ff @(posedge CLK) begin
        fill_buf <= fill_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_FILLING;
            col       <= '0;
            fill_row  <= '0;
            pix_ready <= 1'b1;
            row_out   <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            row_last  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= accept && sof && (col != '0);

            if (accept) begin
                col <= row_done ? '0 : wr_col + CW'(1);
                if (sof) begin
                    fill_row <= '0;
                end
            end

            if (row_done && !slot_free) begin
                state     <= ST_HELD;
                pix_ready <= 1'b0;
            end

            if (load) begin
                row_out   <= fill_next;
                row_idx   <= load_row;
                row_last  <= (load_row == RIW'(ROWS - 1));
                row_valid <= 1'b1;
                fill_row  <= row_inc;
                state     <= ST_FILLING;
                pix_ready <= 1'b1;
            end else if (row_valid && row_ready) begin
                row_valid <= 1'b0;
            end
        end
    end

endmodule
